// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   - AXI read-channel constants driven on the AR channel
//   - fetch_state_t: request FSM states
//   - fq_entry_t: one fetch-queue entry (PC of the pair + both instructions)
package fetch_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam logic [7:0] LEN_1      = 8'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } fetch_state_t;

  // instr[31:0] is the instruction at pc, instr[63:32] the one at pc+4
  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of fq_entry_t feeding decode.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   push, push_data  write one entry (ignored when full unless popping too)
//   pop              remove head (ignored when empty)
//   flush            empty the queue; wins over push/pop
//   head             current head entry (all zeros when empty)
//   full, empty      occupancy flags
//   count            number of valid entries
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fq_entry_t        push_data,
  input  logic             pop,
  input  logic             flush,
  output fq_entry_t        head,
  output logic             full,
  output logic             empty,
  output logic [DEPTH:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = DEPTH + 1;

  fq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // When full, a simultaneous pop frees the head slot that wr_ptr points at.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of the instruction cache.
// Holds the fetch PC, issues single-beat 64-bit reads (one outstanding at a
// time), queues returned instruction pairs and presents them to decode.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   arvalid/araddr/arburst/
//   arsize/arlen/arready         cache read-address channel (word address)
//   rvalid/rdata/rlast/rready    cache read-data channel (rlast ignored)
//   redirect_valid/redirect_pc   flush everything and restart at redirect_pc
//   dec_valid/dec_ready          decode handshake on the queue head
//   dec_pc/dec_instr0/dec_instr1 head pair: instr0 at dec_pc, instr1 at +4
// Optional (macro FETCH_PERF_CNT_EN):
//   perf_fetch_cnt               pairs pushed into the queue
//   perf_stall_cnt               cycles with dec_ready=1 and dec_valid=0
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        arvalid,
  output logic [31:0] araddr,
  output logic [1:0]  arburst,
  output logic [2:0]  arsize,
  output logic [7:0]  arlen,
  input  logic        arready,
  input  logic        rvalid,
  input  logic [63:0] rdata,
  input  logic        rlast,
  output logic        rready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_instr0,
  output logic [31:0] dec_instr1
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int unsigned CNT_W = FQ_DEPTH + 1;

  fetch_state_t   state, state_nxt;
  logic [31:0]    fetch_pc, fetch_pc_nxt;
  logic [31:0]    req_pc, req_pc_nxt;
  logic           drop, drop_nxt;

  logic           fq_push;
  logic           fq_full;
  logic           fq_empty;
  logic [FQ_DEPTH:0] fq_count;
  fq_entry_t      fq_in;
  fq_entry_t      fq_head;
  logic [3:0]     unused_sig;

  assign unused_sig = {rlast, fq_full, req_pc[1:0]};

  assign arburst = BURST_INCR;
  assign arsize  = SIZE_8B;
  assign arlen   = LEN_1;
  assign araddr  = {2'b00, req_pc[31:2]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      drop     <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      req_pc   <= req_pc_nxt;
      drop     <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_pc_nxt   = req_pc;
    drop_nxt     = drop;
    arvalid      = 1'b0;
    rready       = 1'b0;
    fq_push      = 1'b0;
    case (state)
      IDLE: begin
        if (redirect_valid) begin
          fetch_pc_nxt = redirect_pc;
        end else if (fq_count < CNT_W'(FQ_DEPTH)) begin
          state_nxt  = AR;
          req_pc_nxt = fetch_pc;
        end
      end
      AR: begin
        arvalid = 1'b1;
        if (arready) begin
          state_nxt = R;
          // drop already set means fetch_pc holds a redirect target
          if (!drop) fetch_pc_nxt = fetch_pc + 32'd8;
        end
        if (redirect_valid) begin
          drop_nxt     = 1'b1;
          fetch_pc_nxt = redirect_pc;
        end
      end
      R: begin
        rready = 1'b1;
        if (rvalid) begin
          state_nxt = IDLE;
          drop_nxt  = 1'b0;
          fq_push   = !drop && !redirect_valid;
        end
        if (redirect_valid) begin
          fetch_pc_nxt = redirect_pc;
          // a response arriving with the redirect is discarded directly
          drop_nxt     = !rvalid;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fq_in.pc    = req_pc;
  assign fq_in.instr = rdata;

  fetch_queue #(
    .DEPTH(FQ_DEPTH)
  ) u_fetch_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (fq_push),
    .push_data(fq_in),
    .pop      (dec_ready),
    .flush    (redirect_valid),
    .head     (fq_head),
    .full     (fq_full),
    .empty    (fq_empty),
    .count    (fq_count)
  );

  assign dec_valid  = !fq_empty;
  assign dec_pc     = fq_head.pc;
  assign dec_instr0 = fq_head.instr[31:0];
  assign dec_instr1 = fq_head.instr[63:32];

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (fq_push) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (dec_ready && !dec_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
